video_mix: RTL and testbench



---
 rtl/m92_pkg.sv | 24 ++
 rtl/palette_ram.sv | 31 +++
 rtl/video_mix.sv | 165 ++++++++++++++++
 tb/tb_video_mix.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/m92_pkg.sv
// Shared video types for the M92 pixel path: sprite/playfield pixel layouts,
// CPU palette window base and the 5-to-8 bit colour expansion.
package m92_pkg;

    typedef struct packed {
        logic       prio;
        logic [6:0] color;
        logic [3:0] pix;
    } spr_pix_t;

    typedef struct packed {
        logic       hi_prio;
        logic [6:0] color;
        logic [3:0] pix;
        logic       opaque;
    } pf_pix_t;

    localparam logic [7:0] PALETTE_CPU_BASE = 8'hF8;

    function automatic logic [7:0] rgb555_expand(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

endpackage

// File: rtl/palette_ram.sv
// True dual-port 16-bit palette RAM: byte-enabled CPU port A, read-only display port B.
// Port B returns the old word when port A writes the same address in the same cycle.
module palette_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic          we_a,
    input  logic [1:0]    be_a,
    input  logic [15:0]   din_a,
    output logic [15:0]   q_a,
    input  logic          en_b,
    input  logic [AW-1:0] addr_b,
    output logic [15:0]   q_b
);

    logic [15:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we_a) begin
            if (be_a[0]) mem[addr_a][7:0]  <= din_a[7:0];
            if (be_a[1]) mem[addr_a][15:8] <= din_a[15:8];
        end
        q_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        if (en_b) q_b <= mem[addr_b];
    end

endmodule

// File: rtl/video_mix.sv
// Final pixel stage: sprite/playfield priority, palette lookup, RGB out with delayed blanking.
// Define VIDEO_MIX_LAYER_MASK_EN to add the per-layer enable input layer_mask.
module video_mix
    import m92_pkg::*;
#(
    parameter int unsigned PAL_AW   = 12,
    parameter logic [7:0]  CPU_BASE = PALETTE_CPU_BASE
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        CE_PIX,
    input  logic        HBLK,
    input  logic        VBLK,
    input  logic [11:0] spr_pix,
    input  logic [12:0] pf0,
    input  logic [12:0] pf1,
    input  logic [12:0] pf2,
    input  logic        PAL_BANK,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    input  logic [19:0] A,
    input  logic [1:0]  BYTE_SEL,
    input  logic        MRD,
    input  logic        MWR,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
`ifdef VIDEO_MIX_LAYER_MASK_EN
    input  logic [3:0]  layer_mask,
`endif
    output logic        HB_OUT,
    output logic        VB_OUT
);

    logic [3:0] lmask;
`ifdef VIDEO_MIX_LAYER_MASK_EN
    assign lmask = layer_mask;
`else
    assign lmask = '1;
`endif

    // Masking is applied at sample time; a masked pf2 collapses to colour 0 / pix 0
    spr_pix_t spr_in;
    pf_pix_t  pf0_in, pf1_in, pf2_in;

    always_comb begin
        spr_in = spr_pix;
        pf0_in = pf0;
        pf1_in = pf1;
        pf2_in = pf2;
        if (!lmask[3]) spr_in.pix = '0;
        if (!lmask[2]) pf0_in.pix = '0;
        if (!lmask[1]) pf1_in.pix = '0;
        if (!lmask[0]) pf2_in     = '0;
    end

    spr_pix_t s0_spr;
    pf_pix_t  s0_pf0, s0_pf1, s0_pf2;
    logic     s0_hb, s0_vb;

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            s0_spr <= '0;
            s0_pf0 <= '0;
            s0_pf1 <= '0;
            s0_pf2 <= '0;
            s0_hb  <= 1'b1;
            s0_vb  <= 1'b1;
        end else if (CE_PIX) begin
            s0_spr <= spr_in;
            s0_pf0 <= pf0_in;
            s0_pf1 <= pf1_in;
            s0_pf2 <= pf2_in;
            s0_hb  <= HBLK;
            s0_vb  <= VBLK;
        end
    end

    pf_pix_t    win;
    logic       spr_on;
    logic [6:0] win_color;
    logic [3:0] win_pix;

    always_comb begin
        win = s0_pf2;
        if (s0_pf1.pix != '0) win = s0_pf1;
        if (s0_pf0.pix != '0) win = s0_pf0;
        spr_on = (s0_spr.pix != '0) &&
                 !(!s0_spr.prio && win.hi_prio && (win.pix != '0));
        win_color = spr_on ? s0_spr.color : win.color;
        win_pix   = spr_on ? s0_spr.pix   : win.pix;
    end

    logic [PAL_AW-1:0] s1_idx;
    logic              s1_hb, s1_vb;
    logic              s2_hb, s2_vb;

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            s1_idx <= '0;
            s1_hb  <= 1'b1;
            s1_vb  <= 1'b1;
            s2_hb  <= 1'b1;
            s2_vb  <= 1'b1;
        end else if (CE_PIX) begin
            s1_idx <= {PAL_BANK, win_color, win_pix};
            s1_hb  <= s0_hb;
            s1_vb  <= s0_vb;
            s2_hb  <= s1_hb;
            s2_vb  <= s1_vb;
        end
    end

    logic              cpu_sel, cpu_rd_q;
    logic [PAL_AW-1:0] cpu_addr;
    logic [15:0]       pal_qa, pal_qb;

    assign cpu_sel  = (A[19:12] == CPU_BASE);
    assign cpu_addr = {PAL_BANK, A[11:1]};

    palette_ram #(.AW(PAL_AW)) u_pal (
        .clk    (CLK_32M),
        .addr_a (cpu_addr),
        .we_a   (cpu_sel & MWR),
        .be_a   (BYTE_SEL),
        .din_a  (DIN),
        .q_a    (pal_qa),
        .en_b   (CE_PIX),
        .addr_b (s1_idx),
        .q_b    (pal_qb)
    );

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) cpu_rd_q <= 1'b0;
        else       cpu_rd_q <= cpu_sel & MRD;
    end

    assign DOUT = cpu_rd_q ? pal_qa : '0;

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            R      <= '0;
            G      <= '0;
            B      <= '0;
            HB_OUT <= 1'b1;
            VB_OUT <= 1'b1;
        end else if (CE_PIX) begin
            if (s2_hb || s2_vb) begin
                R <= '0;
                G <= '0;
                B <= '0;
            end else begin
                R <= rgb555_expand(pal_qb[4:0]);
                G <= rgb555_expand(pal_qb[9:5]);
                B <= rgb555_expand(pal_qb[14:10]);
            end
            HB_OUT <= s2_hb;
            VB_OUT <= s2_vb;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{A[0], pal_qb[15], s0_pf0.opaque, s0_pf1.opaque, s0_pf2.opaque};

endmodule

// File: tb/tb_video_mix.sv
// Directed bench for video_mix: palette access, priority, latency, blanking, bank, reset, collision.
module tb_video_mix;

    logic        CLK_32M = 1'b0;
    logic        reset = 1'b1;
    logic        CE_PIX = 1'b0;
    logic        HBLK = 1'b0, VBLK = 1'b0;
    logic [11:0] spr_pix = '0;
    logic [12:0] pf0 = '0, pf1 = '0, pf2 = '0;
    logic        PAL_BANK = 1'b0;
    logic [15:0] DIN = '0;
    logic [15:0] DOUT;
    logic [19:0] A = '0;
    logic [1:0]  BYTE_SEL = '0;
    logic        MRD = 1'b0, MWR = 1'b0;
    logic [7:0]  R, G, B;
    logic        HB_OUT, VB_OUT;

    int n_checks = 0;
    int n_errors = 0;

    video_mix dut (
        .CLK_32M  (CLK_32M),
        .reset    (reset),
        .CE_PIX   (CE_PIX),
        .HBLK     (HBLK),
        .VBLK     (VBLK),
        .spr_pix  (spr_pix),
        .pf0      (pf0),
        .pf1      (pf1),
        .pf2      (pf2),
        .PAL_BANK (PAL_BANK),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .A        (A),
        .BYTE_SEL (BYTE_SEL),
        .MRD      (MRD),
        .MWR      (MWR),
        .R        (R),
        .G        (G),
        .B        (B),
`ifdef VIDEO_MIX_LAYER_MASK_EN
        .layer_mask (4'hF),
`endif
        .HB_OUT   (HB_OUT),
        .VB_OUT   (VB_OUT)
    );

    always #5 CLK_32M = ~CLK_32M;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic pix_ticks(input int n);
        CE_PIX = 1'b1;
        repeat (n) tick();
        CE_PIX = 1'b0;
    endtask

    task automatic cpu_write(input logic [19:0] addr, input logic [15:0] data, input logic [1:0] be);
        A = addr;
        DIN = data;
        BYTE_SEL = be;
        MWR = 1'b1;
        tick();
        MWR = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [19:0] addr, input logic [15:0] exp);
        A = addr;
        MRD = 1'b1;
        tick();
        check(tag, {8'h0, DOUT}, {8'h0, exp});
        MRD = 1'b0;
    endtask

    function automatic logic [12:0] mk_pf(input logic hi, input logic [6:0] col, input logic [3:0] pix);
        return {hi, col, pix, pix != 4'h0};
    endfunction

    function automatic logic [11:0] mk_spr(input logic pr, input logic [6:0] col, input logic [3:0] pix);
        return {pr, col, pix};
    endfunction

    initial begin
        repeat (2) tick();
        check("rst_rgb", {R, G, B}, 24'h0);
        check("rst_dout", {8'h0, DOUT}, 24'h0);
        check("rst_hb", {23'h0, HB_OUT}, 24'h1);
        check("rst_vb", {23'h0, VB_OUT}, 24'h1);
        reset = 1'b0;
        tick();

        // CPU window access
        cpu_write(20'hF8002, 16'h7C1F, 2'b11);
        cpu_read("pal_readback", 20'hF8002, 16'h7C1F);
        tick();
        check("dout_idle", {8'h0, DOUT}, 24'h0);
        cpu_read("dout_nosel", 20'h10002, 16'h0000);
        cpu_write(20'hF8002, 16'hAB55, 2'b01);
        cpu_read("byte_lane", 20'hF8002, 16'h7C55);

        // Palette contents: 0x053 red, 0x202 {R,G}=0x10, 0x101 blue, 0x853 green
        cpu_write(20'hF80A6, 16'h001F, 2'b11);
        cpu_write(20'hF8404, 16'h0210, 2'b11);
        cpu_write(20'hF8202, 16'h7C00, 2'b11);
        PAL_BANK = 1'b1;
        cpu_write(20'hF80A6, 16'h03E0, 2'b11);
        cpu_read("bank1_readback", 20'hF80A6, 16'h03E0);
        PAL_BANK = 1'b0;

        // Basic lookup and latency
        pf2 = mk_pf(1'b0, 7'h05, 4'h3);
        pix_ticks(3);
        check("lat_3", {R, G, B}, 24'h000000);
        pix_ticks(1);
        check("lookup", {R, G, B}, 24'hFF0000);
        check("lookup_hb", {23'h0, HB_OUT}, 24'h0);

        // Priority
        spr_pix = mk_spr(1'b0, 7'h10, 4'h1);
        pf0 = mk_pf(1'b1, 7'h20, 4'h2);
        pix_ticks(4);
        check("pf0_hi_over_spr", {R, G, B}, 24'h848400);
        spr_pix = mk_spr(1'b1, 7'h10, 4'h1);
        pix_ticks(4);
        check("spr_prio", {R, G, B}, 24'h0000FF);
        spr_pix = mk_spr(1'b0, 7'h10, 4'h1);
        pf0 = mk_pf(1'b0, 7'h20, 4'h2);
        pix_ticks(4);
        check("spr_over_pf0_lo", {R, G, B}, 24'h0000FF);
        spr_pix = mk_spr(1'b1, 7'h10, 4'h0);
        pf0 = '0;
        pf1 = mk_pf(1'b0, 7'h20, 4'h2);
        pix_ticks(4);
        check("pf1_over_pf2", {R, G, B}, 24'h848400);
        spr_pix = mk_spr(1'b0, 7'h10, 4'h1);
        pf1 = '0;
        pf2 = mk_pf(1'b1, 7'h05, 4'h3);
        pix_ticks(4);
        check("pf2_hi_over_spr", {R, G, B}, 24'hFF0000);
        spr_pix = '0;
        pf2 = mk_pf(1'b0, 7'h05, 4'h3);

        // Outputs hold without CE_PIX
        pix_ticks(4);
        pf2 = mk_pf(1'b0, 7'h20, 4'h2);
        HBLK = 1'b1;
        repeat (5) tick();
        check("ce_hold_rgb", {R, G, B}, 24'hFF0000);
        check("ce_hold_hb", {23'h0, HB_OUT}, 24'h0);
        HBLK = 1'b0;
        pf2 = mk_pf(1'b0, 7'h05, 4'h3);
        pix_ticks(4);

        // Blanking
        HBLK = 1'b1;
        pix_ticks(3);
        check("hb_lat3", {23'h0, HB_OUT}, 24'h0);
        check("hb_lat3_rgb", {R, G, B}, 24'hFF0000);
        pix_ticks(1);
        check("hb_lat4", {23'h0, HB_OUT}, 24'h1);
        check("hblank_rgb", {R, G, B}, 24'h000000);
        HBLK = 1'b0;
        VBLK = 1'b1;
        pix_ticks(4);
        check("vb_lat4", {23'h0, VB_OUT}, 24'h1);
        check("vblank_rgb", {R, G, B}, 24'h000000);
        VBLK = 1'b0;
        pix_ticks(4);
        check("vb_clear", {23'h0, VB_OUT}, 24'h0);
        check("unblank_rgb", {R, G, B}, 24'hFF0000);

        // Bank switch
        PAL_BANK = 1'b1;
        pix_ticks(4);
        check("bank1", {R, G, B}, 24'h00FF00);
        PAL_BANK = 1'b0;
        pix_ticks(4);
        check("bank0", {R, G, B}, 24'hFF0000);

        // Reset mid-stream
        CE_PIX = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_rgb", {R, G, B}, 24'h000000);
        check("rst_mid_hb", {23'h0, HB_OUT}, 24'h1);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("rst_rel_%0d", i), {R, G, B}, 24'h000000);
        end
        tick();
        check("rst_rel_4", {R, G, B}, 24'hFF0000);

        // Same-address CPU write during display read: old word first, new word next
        repeat (2) tick();
        A = 20'hF80A6;
        DIN = 16'h03E0;
        BYTE_SEL = 2'b11;
        MWR = 1'b1;
        tick();
        MWR = 1'b0;
        check("coll_e1", {R, G, B}, 24'hFF0000);
        tick();
        check("coll_old", {R, G, B}, 24'hFF0000);
        tick();
        check("coll_new", {R, G, B}, 24'h00FF00);
        CE_PIX = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
